// File: rtl/jk_seq_pkg.sv
// rtl/jk_seq_pkg.sv - shared opcode and FSM state types for the JK bank sequencer
//
// Purpose: the command opcode encoding and the sequencer FSM state
//          encoding, shared by the controller and its bench.
// Ports:   none (package)
package jk_seq_pkg;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_LOAD   = 3'd1,
    OP_CLEAR  = 3'd2,
    OP_SET    = 3'd3,
    OP_TOGGLE = 3'd4,
    OP_CNT_UP = 3'd5,
    OP_CNT_DN = 3'd6,
    OP_RSVD   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/jk_cell.sv
// rtl/jk_cell.sv - single JK flip-flop cell with synchronous active-high reset
//
// Purpose: one storage cell of the bank.
//          {j,k} = 00 hold, 01 clear, 10 set, 11 toggle.
// Ports:   clk   - clock, rising edge
//          reset - synchronous, active-high; forces q=0 / qn=1
//          j, k  - JK drive
//          q, qn - cell output and its complement
module jk_cell (
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qn
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

  assign qn = ~q;

endmodule

// File: rtl/jk_bank_sequencer.sv
// rtl/jk_bank_sequencer.sv - command-driven sequencer for a bank of JK cells
//
// Purpose: accepts opcodes over a valid/ready handshake and turns each one
//          into per-bit J/K drive for a bank of WIDTH JK cells. It supports
//          load, clear, set, masked toggle and multi-step up/down counting.
//          Completion is signalled by a one-cycle done pulse.
// Ports:   clk, reset         - clock, synchronous active-high reset
//          cmd_valid/cmd_ready - command handshake (ready only in IDLE)
//          cmd_op              - opcode (jk_seq_pkg::op_e encoding)
//          cmd_data            - LOAD value or TOGGLE mask
//          cmd_len             - number of CNT_UP/CNT_DN steps
//          q, qn               - bank outputs (qn == ~q)
//          busy                - high in EXEC or COUNT
//          done                - one-cycle pulse after the final bank update
module jk_bank_sequencer
  import jk_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_len,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  op_e              op_q;
  op_e              cmd_op_e;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] j_vec, k_vec;
  logic [WIDTH-1:0] t_vec;
  logic             carry;
  logic             accept;

  assign cmd_op_e  = op_e'(cmd_op);
  assign cmd_ready = (state_q == ST_IDLE) && !reset;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state_q == ST_EXEC) || (state_q == ST_COUNT);
  assign done      = (state_q == ST_DONE);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    j_vec   = '0;
    k_vec   = '0;
    t_vec   = '0;
    carry   = 1'b1;

    // Ripple toggle enables: a bit flips when every lower bit is 1 (up)
    // or every lower bit is 0 (down); bit 0 always flips.
    for (int i = 0; i < WIDTH; i++) begin
      t_vec[i] = carry;
      carry    = carry & ((op_q == OP_CNT_DN) ? ~q[i] : q[i]);
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if ((cmd_op_e == OP_CNT_UP) || (cmd_op_e == OP_CNT_DN)) begin
            state_d = ST_COUNT;
            rem_d   = cmd_len;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        case (op_q)
          OP_LOAD: begin
            j_vec = data_q;
            k_vec = ~data_q;
          end
          OP_CLEAR:  k_vec = '1;
          OP_SET:    j_vec = '1;
          OP_TOGGLE: begin
            j_vec = data_q;
            k_vec = data_q;
          end
          default: ;
        endcase
        state_d = ST_DONE;
      end
      ST_COUNT: begin
        // A zero-length count still spends one cycle here, leaving q alone.
        if (rem_q == '0) begin
          state_d = ST_DONE;
        end else begin
          j_vec = t_vec;
          k_vec = t_vec;
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      op_q    <= OP_NOP;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      if (accept) begin
        op_q   <= cmd_op_e;
        data_q <= cmd_data;
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .j     (j_vec[i]),
      .k     (k_vec[i]),
      .q     (q[i]),
      .qn    (qn[i])
    );
  end

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// tb/tb_jk_bank_sequencer.sv - directed self-checking bench for jk_bank_sequencer
module tb_jk_bank_sequencer;
  import jk_seq_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data;
  logic [7:0] cmd_len;
  logic [7:0] q;
  logic [7:0] qn;
  logic       busy;
  logic       done;

  int compared   = 0;
  int mismatched = 0;
  int done_count = 0;

  jk_bank_sequencer #(.WIDTH(8), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_len   (cmd_len),
    .q         (q),
    .qn        (qn),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done === 1'b1) done_count <= done_count + 1;
  end

  // Waits (bounded) for cmd_ready at a falling edge, presents one command
  // for one cycle, and returns at the falling edge after the accept edge.
  task automatic send(input logic [2:0] op, input logic [7:0] data, input logic [7:0] len);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (cmd_ready !== 1'b1) begin
      compared++;
      mismatched++;
      $display("FAIL send_wait_ready: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_len   = len;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_data  = 8'h00;
    cmd_len   = 8'h00;
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_data  = 8'h00;
    cmd_len   = 8'h00;
    @(negedge clk);
    @(negedge clk);
    compared++; if (q !== 8'h00) begin mismatched++; $display("FAIL reset_q: got %h required 00", q); end
    compared++; if (qn !== 8'hFF) begin mismatched++; $display("FAIL reset_qn: got %h required ff", qn); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b required 0", busy); end
    compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %b required 0", done); end
    compared++; if (cmd_ready !== 1'b0) begin mismatched++; $display("FAIL reset_ready: got %b required 0", cmd_ready); end
    reset = 1'b0;
    #1;
    compared++; if (cmd_ready !== 1'b1) begin mismatched++; $display("FAIL reset_release_ready: got %b required 1", cmd_ready); end
  endtask

  task automatic test_load;
    int d0 = done_count;
    send(OP_LOAD, 8'hA5, 8'h00);
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL load_exec_busy: got %b required 1", busy); end
    compared++; if (cmd_ready !== 1'b0) begin mismatched++; $display("FAIL load_exec_ready: got %b required 0", cmd_ready); end
    compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL load_exec_done: got %b required 0", done); end
    compared++; if (q !== 8'h00) begin mismatched++; $display("FAIL load_exec_q: got %h required 00", q); end
    @(negedge clk);
    compared++; if (q !== 8'hA5) begin mismatched++; $display("FAIL load_q: got %h required a5", q); end
    compared++; if (qn !== 8'h5A) begin mismatched++; $display("FAIL load_qn: got %h required 5a", qn); end
    compared++; if (done !== 1'b1) begin mismatched++; $display("FAIL load_done: got %b required 1", done); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL load_done_busy: got %b required 0", busy); end
    compared++; if (cmd_ready !== 1'b0) begin mismatched++; $display("FAIL load_done_ready: got %b required 0", cmd_ready); end
    @(negedge clk);
    compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL load_done_fall: got %b required 0", done); end
    compared++; if (cmd_ready !== 1'b1) begin mismatched++; $display("FAIL load_ready_back: got %b required 1", cmd_ready); end
    compared++; if (done_count - d0 !== 1) begin mismatched++; $display("FAIL load_done_pulses: got %0d required 1", done_count - d0); end
  endtask

  task automatic test_toggle_set_clear;
    logic [2:0] ops  [3] = '{OP_TOGGLE, OP_SET, OP_CLEAR};
    logic [7:0] data [3] = '{8'h0F, 8'h00, 8'hFF};
    logic [7:0] exp  [3] = '{8'hAA, 8'hFF, 8'h00};
    for (int i = 0; i < 3; i++) begin
      int d0 = done_count;
      send(ops[i], data[i], 8'h00);
      @(negedge clk);
      compared++; if (q !== exp[i]) begin mismatched++; $display("FAIL tsc_q[%0d]: got %h required %h", i, q, exp[i]); end
      compared++; if (done !== 1'b1) begin mismatched++; $display("FAIL tsc_done[%0d]: got %b required 1", i, done); end
      @(negedge clk);
      compared++; if (done_count - d0 !== 1) begin mismatched++; $display("FAIL tsc_pulses[%0d]: got %0d required 1", i, done_count - d0); end
    end
  endtask

  task automatic test_count;
    logic [7:0] up_seq [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    logic [7:0] dn_seq [3] = '{8'h01, 8'h00, 8'hFF};
    int d0;
    send(OP_LOAD, 8'hFE, 8'h00);
    @(negedge clk);
    @(negedge clk);
    d0 = done_count;
    send(OP_CNT_UP, 8'h00, 8'd3);
    for (int k = 0; k < 3; k++) begin
      compared++; if (q !== up_seq[k]) begin mismatched++; $display("FAIL up_q[%0d]: got %h required %h", k, q, up_seq[k]); end
      compared++; if (busy !== 1'b1 || done !== 1'b0) begin mismatched++; $display("FAIL up_busy[%0d]: got busy=%b done=%b required busy=1 done=0", k, busy, done); end
      @(negedge clk);
    end
    compared++; if (q !== up_seq[3]) begin mismatched++; $display("FAIL up_q_final: got %h required %h", q, up_seq[3]); end
    compared++; if (busy !== 1'b0 || done !== 1'b1) begin mismatched++; $display("FAIL up_done: got busy=%b done=%b required busy=0 done=1", busy, done); end
    @(negedge clk);
    compared++; if (done_count - d0 !== 1) begin mismatched++; $display("FAIL up_pulses: got %0d required 1", done_count - d0); end
    d0 = done_count;
    send(OP_CNT_DN, 8'h00, 8'd2);
    for (int k = 0; k < 2; k++) begin
      compared++; if (q !== dn_seq[k] || busy !== 1'b1) begin mismatched++; $display("FAIL dn_q[%0d]: got q=%h busy=%b required q=%h busy=1", k, q, busy, dn_seq[k]); end
      @(negedge clk);
    end
    compared++; if (q !== dn_seq[2] || done !== 1'b1) begin mismatched++; $display("FAIL dn_final: got q=%h done=%b required q=%h done=1", q, done, dn_seq[2]); end
    @(negedge clk);
    compared++; if (done_count - d0 !== 1) begin mismatched++; $display("FAIL dn_pulses: got %0d required 1", done_count - d0); end
  endtask

  task automatic test_cnt_zero_ignore;
    int d0 = done_count;
    send(OP_CNT_DN, 8'h00, 8'd0);
    compared++; if (busy !== 1'b1 || q !== 8'hFF) begin mismatched++; $display("FAIL zero_count_cycle: got busy=%b q=%h required busy=1 q=ff", busy, q); end
    cmd_valid = 1'b1;
    cmd_op    = OP_LOAD;
    cmd_data  = 8'h33;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_data  = 8'h00;
    compared++; if (done !== 1'b1 || q !== 8'hFF) begin mismatched++; $display("FAIL zero_done: got done=%b q=%h required done=1 q=ff", done, q); end
    @(negedge clk);
    @(negedge clk);
    compared++; if (q !== 8'hFF || busy !== 1'b0) begin mismatched++; $display("FAIL ignored_load: got q=%h busy=%b required q=ff busy=0", q, busy); end
    compared++; if (done_count - d0 !== 1) begin mismatched++; $display("FAIL zero_pulses: got %0d required 1", done_count - d0); end
  endtask

  task automatic test_reset_abort;
    int d0;
    send(OP_LOAD, 8'h00, 8'h00);
    @(negedge clk);
    @(negedge clk);
    d0 = done_count;
    send(OP_CNT_UP, 8'h00, 8'd10);
    for (int k = 0; k < 4; k++) @(negedge clk);
    compared++; if (q !== 8'h04 || busy !== 1'b1) begin mismatched++; $display("FAIL abort_pre_q: got q=%h busy=%b required q=04 busy=1", q, busy); end
    reset = 1'b1;
    @(negedge clk);
    compared++; if (q !== 8'h00 || qn !== 8'hFF) begin mismatched++; $display("FAIL abort_q: got q=%h qn=%h required q=00 qn=ff", q, qn); end
    compared++; if (busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b0) begin mismatched++; $display("FAIL abort_ctl: got busy=%b done=%b ready=%b required 0 0 0", busy, done, cmd_ready); end
    reset = 1'b0;
    for (int k = 0; k < 4; k++) @(negedge clk);
    compared++; if (q !== 8'h00 || busy !== 1'b0 || cmd_ready !== 1'b1) begin mismatched++; $display("FAIL abort_after: got q=%h busy=%b ready=%b required q=00 busy=0 ready=1", q, busy, cmd_ready); end
    compared++; if (done_count - d0 !== 0) begin mismatched++; $display("FAIL abort_pulses: got %0d required 0", done_count - d0); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_toggle_set_clear();
    test_count();
    test_cnt_zero_ignore();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/jk_bank_sequencer.md
# jk_bank_sequencer

Command-driven controller that sequences a bank of WIDTH JK flip-flop cells. It translates one-hot-free opcodes into per-bit J/K drive: load, clear, set, masked toggle, and multi-step synchronous up/down counting. It sits between a command source with a valid/ready handshake and the JK register bank it owns. It reports completion with a single-cycle done pulse.

## Interface

Parameters:
- WIDTH, 8, number of JK cells in the bank (≥2)
- CNT_W, 8, width of the count-length field

Ports:
- clk  in  1  clock; all state updates on its rising edge
- reset  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd_op  in  3  opcode: 0 NOP, 1 LOAD, 2 CLEAR, 3 SET, 4 TOGGLE, 5 CNT_UP, 6 CNT_DN, 7 reserved (treated as NOP)
- cmd_data  in  WIDTH  LOAD value, or TOGGLE mask
- cmd_len  in  CNT_W  number of count steps for CNT_UP/CNT_DN
- q  out  WIDTH  bank Q outputs
- qn  out  WIDTH  bank Qn outputs, always ~q
- busy  out  1  high in EXEC or COUNT
- done  out  1  one-cycle pulse after the command's final bank update

## Operation

- FSM states: IDLE, EXEC, COUNT, DONE.
- cmd_ready = (state==IDLE) && !reset.
- **Accept.** A command is accepted on an edge where cmd_valid && cmd_ready. op, data and len are registered at that edge. Inputs are ignored at all other times.
- **IDLE transitions.** Accepting CNT_UP or CNT_DN goes to COUNT, with remaining = len. Accepting any other op goes to EXEC.
- **EXEC (one cycle).** Per bit i, J/K are driven as follows:
  - LOAD: J=d[i], K=~d[i].
  - CLEAR: J=0, K=1.
  - SET: J=1, K=0.
  - TOGGLE: J=K=m[i].
  - NOP/reserved: J=K=0.
  - Next state is DONE.
- **COUNT.**
  - remaining==0: J=K=0 for all bits. Next state is DONE, and q is unchanged.
  - remaining>0: up-count uses t[0]=1 and t[i]=&q[i-1:0]; down-count uses t[i]=&~q[i-1:0]. Drive J=K=t. Decrement remaining.
  - When remaining reaches 0 after a step, go to DONE. Otherwise stay in COUNT.
  - Arithmetic is modulo 2^WIDTH: 0xFF+1 gives 0x00, and 0x00−1 gives 0xFF.
- **DONE (one cycle).** done=1, J=K=0, next state is IDLE.
- **Reset.**
  - When reset is high at an edge: q=0, qn=all-ones, state=IDLE, remaining=0, done=0, busy=0.
  - reset overrides any in-flight command. The aborted command gets no done pulse.
  - reset overrides accept: no command is accepted while reset is high.
- **Handshake.** cmd_valid asserted while busy is ignored and not queued. The source must hold the command until it sees cmd_ready.

## Timing

- Accept edge E0. A non-count op is in EXEC during cycle E0→E1. q shows the new value after E1, and done is high during cycle E1→E2. cmd_ready returns in the cycle after E2.
- Throughput for single ops is one command per 3 cycles.
- CNT with len=n, n≥1:
  - q advances once per edge E1..En.
  - busy is high for n cycles.
  - done is high in cycle En→En+1.
- CNT with len=0: one COUNT cycle, then done in cycle E1→E2, with q unchanged.
- busy and done are never high in the same cycle.
- done is registered state decode and is glitch-free.

## Structure

- Package jk_seq_pkg holds:
  - the opcode enum (OP_NOP … OP_RSVD, 3 bits)
  - the FSM state enum (ST_IDLE, ST_EXEC, ST_COUNT, ST_DONE)
- Sub-module jk_cell has ports clk, reset, j, k, q, qn.
  - Behaviour: sync active-high reset to q=0/qn=1; hold on 00; clear on 01; set on 10; toggle on 11.
  - It is instantiated WIDTH times in a generate loop.
- The controller computes only the J/K vectors and never writes q directly.

## Test plan

- Reset for 2 cycles → q=0x00, qn=0xFF, busy=0, done=0. cmd_ready=0 during reset and 1 on the first cycle after reset drops.
- LOAD 0xA5 → q=0xA5 after E1; exactly one done pulse in cycle E1→E2; cmd_ready low for cycles E0→E2.
- From 0xA5, TOGGLE mask 0x0F → q=0xAA. Then SET → 0xFF. Then CLEAR → 0x00. Each op gets one done pulse.
- From 0xFE, CNT_UP len=3 → q sequence 0xFF, 0x00, 0x01 on consecutive edges; busy high 3 cycles; single done pulse. Then CNT_DN len=2 → 0x00, 0xFF.
- CNT_DN len=0 → q unchanged, done in cycle E1→E2. A cmd_valid LOAD 0x33 pulsed during busy is ignored, so q stays unchanged.
- CNT_UP len=10 from 0x00, with reset asserted after 4 steps (q=0x04) → q=0x00 on the reset edge, state IDLE, no done pulse, no further counting.
